// File: rtl/uart_rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_defs
//   Shared encodings and constants for the UART ROM loader.
//   - rx_state_t : serial receiver states
//   - ld_state_t : image loader states
//   - BYTES_PER_WORD : bytes assembled into one ROM word
// ---------------------------------------------------------------------------
package loader_defs;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        L_LEN_LO = 3'd0,
        L_LEN_HI = 3'd1,
        L_WORD   = 3'd2,
        L_WRITE  = 3'd3,
        L_DONE   = 3'd4
    } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver. The raw line is double-flopped, the start bit is
//   confirmed at its midpoint, and every later bit is sampled one bit
//   period after the previous one (i.e. at bit centres).
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   rx         in   raw serial line, idle high
//   byte_valid out  one-cycle pulse, byte_data holds a good byte
//   byte_data  out  last received byte
//   frame_err  out  one-cycle pulse, stop bit sampled low (byte dropped)
// ---------------------------------------------------------------------------
module uart_rx_byte
    import loader_defs::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    rx_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            w_rx;
    logic            w_half_done;
    logic            w_bit_done;

    assign w_rx        = r_sync2;
    assign w_half_done = (r_cnt == CNT_W'(HALF - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Line is asynchronous to clock: two flops before any decision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE:  if (!w_rx) w_next_state = RX_START;
            // High at the midpoint means the low sample was a glitch.
            RX_START: if (w_half_done) w_next_state = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = RX_STOP;
            RX_STOP:  if (w_bit_done) w_next_state = RX_IDLE;
            default:  w_next_state = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
                RX_START: begin
                    r_cnt <= w_half_done ? '0 : r_cnt + 1'b1;
                end
                RX_DATA: begin
                    if (w_bit_done) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};  // LSB arrives first
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_data;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_rom_loader.sv
// ---------------------------------------------------------------------------
// uart_rom_loader
//   Receives a length-prefixed little-endian program image over UART and
//   writes it word by word into the CPU instruction ROM, then releases the
//   CPU. Image: len_lo, len_hi (word count N), then N words LSB first.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   uart_rx     in   raw serial line, idle high
//   rom_we      out  one-cycle ROM write strobe
//   rom_addr    out  ROM word address (valid with rom_we)
//   rom_wdata   out  ROM write data (valid with rom_we)
//   cpu_enable  out  high once the whole image has been consumed
//   load_error  out  sticky: framing error or image larger than the ROM
// ---------------------------------------------------------------------------
module uart_rom_loader
    import loader_defs::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    output logic                  cpu_enable,
    output logic                  load_error
);

    logic                  w_byte_valid;
    logic [7:0]            w_byte_data;
    logic                  w_frame_err;

    ld_state_t             r_state;
    ld_state_t             w_next_state;
    logic [15:0]           r_len;
    logic [1:0]            r_idx;
    // Word counter doubles as the write address; it is wider than the ROM
    // address so oversized images are counted without wrapping.
    logic [15:0]           r_wcnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_cpu_en;
    logic                  r_err;
    logic                  w_overflow;
    logic                  w_in_write;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .rx         (uart_rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    assign w_overflow = ({16'd0, r_wcnt} >= (32'd1 << ADDR_WIDTH));
    assign w_in_write = (r_state == L_WRITE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= L_LEN_LO;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            L_LEN_LO: if (w_byte_valid) w_next_state = L_LEN_HI;
            L_LEN_HI: begin
                if (w_byte_valid)
                    w_next_state = ({w_byte_data, r_len[7:0]} == 16'd0) ? L_DONE : L_WORD;
            end
            L_WORD: begin
                if (w_byte_valid && (r_idx == 2'(BYTES_PER_WORD - 1)))
                    w_next_state = L_WRITE;
            end
            L_WRITE:  w_next_state = ((r_wcnt + 16'd1) == r_len) ? L_DONE : L_WORD;
            L_DONE:   w_next_state = L_DONE;
            default:  w_next_state = L_LEN_LO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_word   <= '0;
            r_cpu_en <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cpu_en <= (r_state == L_DONE);
            if (w_frame_err || (w_in_write && w_overflow))
                r_err <= 1'b1;
            case (r_state)
                L_LEN_LO: if (w_byte_valid) r_len[7:0] <= w_byte_data;
                L_LEN_HI: begin
                    if (w_byte_valid) begin
                        r_len[15:8] <= w_byte_data;
                        r_idx       <= '0;
                        r_wcnt      <= '0;
                    end
                end
                L_WORD: begin
                    if (w_byte_valid) begin
                        for (int b = 0; b < BYTES_PER_WORD; b++)
                            if (r_idx == 2'(b)) r_word[8*b +: 8] <= w_byte_data;
                        r_idx <= r_idx + 2'd1;
                    end
                end
                L_WRITE:  r_wcnt <= r_wcnt + 16'd1;
                default: ;
            endcase
        end
    end

    assign rom_we     = w_in_write && !w_overflow;
    assign rom_addr   = r_wcnt[ADDR_WIDTH-1:0];
    assign rom_wdata  = r_word;
    assign cpu_enable = r_cpu_en;
    assign load_error = r_err;

endmodule
